// File: rtl/adc_seq_pkg.sv
// Shared types, scan list and slot helpers for the ADC command sequencer.
package adc_seq_pkg;

  localparam int unsigned NUM_SLOTS = 10;
  localparam int unsigned SLOT_W    = 4;
  localparam int unsigned CHAN_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  // Slot i of the scan holds channel SCAN_LIST[i]; slot 9 is the temperature sensor.
  localparam logic [NUM_SLOTS-1:0][CHAN_W-1:0] SCAN_LIST = {
    5'd17, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0
  };

  // Channel number for a slot index; out-of-range slots read as channel 0.
  function automatic logic [CHAN_W-1:0] slot_chan(input logic [SLOT_W-1:0] slot);
    logic [CHAN_W-1:0] ch;
    ch = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (slot == SLOT_W'(i)) ch = SCAN_LIST[i];
    end
    return ch;
  endfunction

  // Lowest enabled slot at or above 'from'; returns NUM_SLOTS when none remain.
  function automatic logic [SLOT_W-1:0] next_en_slot(input logic [NUM_SLOTS-1:0] mask,
                                                     input logic [SLOT_W-1:0]    from);
    logic [SLOT_W-1:0] res;
    res = SLOT_W'(NUM_SLOTS);
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (mask[i] && (SLOT_W'(i) >= from)) res = SLOT_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_scan_timer.sv
// Free-running scan period counter; tick marks the last count of each period.
module adc_scan_timer #(
  parameter int unsigned SCAN_PERIOD = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick_c
);

  localparam int unsigned    CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_PERIOD - 1);

  logic [CNT_W-1:0] r_count;

  // Count 0..SCAN_PERIOD-1 and wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tick_c = (r_count == LAST);

endmodule

// File: rtl/adc_command_sequencer.sv
// Issues one masked scan of ADC conversion commands per period and tracks responses.
module adc_command_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned          SCAN_PERIOD  = 50000,
  parameter logic [NUM_SLOTS-1:0] CHANNEL_MASK = 10'h3FF
) (
  input  logic              Clock_qsys,
  input  logic              Reset_n,
  input  logic              Enable,
  output logic              AdcCommandValid,
  input  logic              AdcCommandReady,
  output logic [CHAN_W-1:0] AdcCommandChannel,
  output logic              AdcCommandStartOfPacket,
  output logic              AdcCommandEndOfPacket,
  input  logic              AdcResponseValid,
  input  logic [CHAN_W-1:0] AdcResponseChannel,
  output logic              ScanBusy,
  output logic              ScanDone,
  output logic              ScanOverrun,
  output logic              SeqError
);

  localparam logic [SLOT_W-1:0] FIRST_SLOT = next_en_slot(CHANNEL_MASK, SLOT_W'(0));
  localparam logic [SLOT_W-1:0] END_SLOT   = SLOT_W'(NUM_SLOTS);
  localparam logic [SLOT_W-1:0] NUM_EN     = SLOT_W'($countones(CHANNEL_MASK));

  seq_state_e        r_state, w_state_nxt;
  logic [SLOT_W-1:0] r_idx, w_idx_nxt;
  logic [SLOT_W-1:0] r_exp, w_exp_nxt;
  logic [SLOT_W-1:0] r_issued, w_issued_nxt;
  logic [SLOT_W-1:0] r_received, w_received_nxt;
  logic              r_valid, w_valid_nxt;
  logic [CHAN_W-1:0] r_chan, w_chan_nxt;
  logic              r_sop, w_sop_nxt;
  logic              r_eop, w_eop_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_overrun, w_overrun_nxt;
  logic              r_seqerr, w_seqerr_nxt;

  logic              w_tick;
  logic              w_hs;
  logic [SLOT_W-1:0] w_next_slot;

  adc_scan_timer #(
    .SCAN_PERIOD(SCAN_PERIOD)
  ) u_timer (
    .i_clk    (Clock_qsys),
    .i_rst_n  (Reset_n),
    .o_tick_c (w_tick)
  );

  assign w_hs        = r_valid & AdcCommandReady;
  assign w_next_slot = next_en_slot(CHANNEL_MASK, r_idx + SLOT_W'(1));

  // State and registered outputs.
  always_ff @(posedge Clock_qsys or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_exp      <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_valid    <= 1'b0;
      r_chan     <= '0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_seqerr   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_exp      <= w_exp_nxt;
      r_issued   <= w_issued_nxt;
      r_received <= w_received_nxt;
      r_valid    <= w_valid_nxt;
      r_chan     <= w_chan_nxt;
      r_sop      <= w_sop_nxt;
      r_eop      <= w_eop_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_overrun  <= w_overrun_nxt;
      r_seqerr   <= w_seqerr_nxt;
    end
  end

  // Next state, command presentation and response bookkeeping.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_exp_nxt      = r_exp;
    w_issued_nxt   = r_issued;
    w_received_nxt = r_received;
    w_valid_nxt    = r_valid;
    w_chan_nxt     = r_chan;
    w_sop_nxt      = r_sop;
    w_eop_nxt      = r_eop;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_overrun_nxt  = r_overrun;
    w_seqerr_nxt   = r_seqerr;

    if (w_hs) w_issued_nxt = r_issued + SLOT_W'(1);

    // A response is only legitimate while busy and for a command already handed over.
    if (AdcResponseValid) begin
      if ((r_state == IDLE) || (r_received >= w_issued_nxt)) begin
        w_seqerr_nxt = 1'b1;
      end else begin
        w_received_nxt = r_received + SLOT_W'(1);
        w_exp_nxt      = next_en_slot(CHANNEL_MASK, r_exp + SLOT_W'(1));
        if (AdcResponseChannel != slot_chan(r_exp)) w_seqerr_nxt = 1'b1;
      end
    end

    if (w_tick && (r_state != IDLE)) w_overrun_nxt = 1'b1;
    if (!Enable) w_overrun_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_tick && Enable && (CHANNEL_MASK != '0)) begin
          w_state_nxt    = ISSUE;
          w_idx_nxt      = FIRST_SLOT;
          w_exp_nxt      = FIRST_SLOT;
          w_issued_nxt   = '0;
          w_received_nxt = '0;
          w_valid_nxt    = 1'b1;
          w_chan_nxt     = slot_chan(FIRST_SLOT);
          w_sop_nxt      = 1'b1;
          w_eop_nxt      = (next_en_slot(CHANNEL_MASK, FIRST_SLOT + SLOT_W'(1)) == END_SLOT);
          w_busy_nxt     = 1'b1;
        end
      end
      ISSUE: begin
        if (w_hs) begin
          if (r_eop) begin
            w_valid_nxt = 1'b0;
            w_chan_nxt  = '0;
            w_sop_nxt   = 1'b0;
            w_eop_nxt   = 1'b0;
            if (w_received_nxt == NUM_EN) begin
              w_state_nxt = IDLE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = DRAIN;
            end
          end else begin
            w_idx_nxt  = w_next_slot;
            w_chan_nxt = slot_chan(w_next_slot);
            w_sop_nxt  = 1'b0;
            w_eop_nxt  = (next_en_slot(CHANNEL_MASK, w_next_slot + SLOT_W'(1)) == END_SLOT);
          end
        end
      end
      DRAIN: begin
        if (w_received_nxt == NUM_EN) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign AdcCommandValid         = r_valid;
  assign AdcCommandChannel       = r_chan;
  assign AdcCommandStartOfPacket = r_sop;
  assign AdcCommandEndOfPacket   = r_eop;
  assign ScanBusy                = r_busy;
  assign ScanDone                = r_done;
  assign ScanOverrun             = r_overrun;
  assign SeqError                = r_seqerr;

endmodule
